// File: rtl/i2c_passthru_tgt_regs_if.sv
// Bus bundle for the passthru I2C target: filtered I2C lines plus the external register port.
// The slave modport is the target's view; the master modport is the surrounding system's view.
interface i2c_passthru_tgt_regs_if #(
    parameter int REG_AW = 4
);
    logic              i_scl;
    logic              i_sda;
    logic              o_sda;
    logic              o_wr_en;
    logic [REG_AW-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
    logic              o_rd_en;
    logic [REG_AW-1:0] o_rd_addr;
    logic [7:0]        i_rd_data;

    modport slave (
        input  i_scl, i_sda, i_rd_data,
        output o_sda, o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr
    );

    modport master (
        output i_scl, i_sda, i_rd_data,
        input  o_sda, o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr
    );
endinterface

// File: rtl/i2c_passthru_tgt_regs.sv
// I2C target behind the passthru input filter: matches its 7-bit address, loads a register
// pointer, then performs byte writes/reads on a simple external register port.
module i2c_passthru_tgt_regs #(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         REG_AW   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    i2c_passthru_tgt_regs_if.slave bus,
    output logic                   o_busy,
    output logic                   o_start_det,
    output logic                   o_stop_det
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic [REG_AW-1:0] PtrOne = REG_AW'(1);

    state_t            state_q, state_d;
    logic              prevScl_q, prevSda_q;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              rdCap_q;
    logic [7:0]        rdByte_q, rdByte_d;
    logic              sda_q, sda_d;
    logic              wrEn_q, wrEn_d;
    logic [REG_AW-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        wrData_q, wrData_d;
    logic              rdEn_q, rdEn_d;
    logic [REG_AW-1:0] rdAddr_q, rdAddr_d;
    logic              startDet_q, startDet_d;
    logic              stopDet_q, stopDet_d;

    logic startSeen, stopSeen, sclRise, sclFall;

    assign startSeen = prevScl_q & bus.i_scl & prevSda_q & ~bus.i_sda;
    assign stopSeen  = prevScl_q & bus.i_scl & ~prevSda_q & bus.i_sda;
    assign sclRise   = ~prevScl_q & bus.i_scl;
    assign sclFall   = prevScl_q & ~bus.i_scl;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            prevScl_q  <= 1'b1;
            prevSda_q  <= 1'b1;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            rdCap_q    <= 1'b0;
            rdByte_q   <= '0;
            sda_q      <= 1'b1;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            rdEn_q     <= 1'b0;
            rdAddr_q   <= '0;
            startDet_q <= 1'b0;
            stopDet_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prevScl_q  <= bus.i_scl;
            prevSda_q  <= bus.i_sda;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            rdCap_q    <= rdEn_q;
            rdByte_q   <= rdByte_d;
            sda_q      <= sda_d;
            wrEn_q     <= wrEn_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            rdEn_q     <= rdEn_d;
            rdAddr_q   <= rdAddr_d;
            startDet_q <= startDet_d;
            stopDet_q  <= stopDet_d;
        end
    end

    // Read data arrives the cycle after the rd strobe and is latched before the next SCL fall.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        rdByte_d   = rdCap_q ? bus.i_rd_data : rdByte_q;
        sda_d      = sda_q;
        wrEn_d     = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        rdEn_d     = 1'b0;
        rdAddr_d   = rdAddr_q;
        startDet_d = 1'b0;
        stopDet_d  = 1'b0;

        if (startSeen) begin
            state_d    = ADDR;
            bitCnt_d   = '0;
            sda_d      = 1'b1;
            startDet_d = 1'b1;
        end else if (stopSeen) begin
            state_d   = IDLE;
            bitCnt_d  = '0;
            sda_d     = 1'b1;
            stopDet_d = 1'b1;
        end else begin
            if (sclRise && bitCnt_q != 4'd8 && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
                shift_d  = {shift_q[6:0], bus.i_sda};
                bitCnt_d = bitCnt_q + 4'd1;
            end
            case (state_q)
                ADDR: begin
                    if (sclFall && bitCnt_q == 4'd8) begin
                        bitCnt_d = '0;
                        if (shift_q[7:1] == TGT_ADDR) begin
                            rw_d    = shift_q[0];
                            sda_d   = 1'b0;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclRise && rw_q) begin
                        rdEn_d   = 1'b1;
                        rdAddr_d = ptr_q;
                        ptr_d    = ptr_q + PtrOne;
                    end
                    if (sclFall) begin
                        if (rw_q) begin
                            sda_d    = rdByte_q[7];
                            bitCnt_d = 4'd1;
                            state_d  = RDATA;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = PTR;
                        end
                    end
                end
                PTR: begin
                    if (sclFall && bitCnt_q == 4'd8) begin
                        ptr_d    = shift_q[REG_AW-1:0];
                        sda_d    = 1'b0;
                        bitCnt_d = '0;
                        state_d  = PTR_ACK;
                    end
                end
                WDATA: begin
                    if (sclFall && bitCnt_q == 4'd8) begin
                        wrEn_d   = 1'b1;
                        wrAddr_d = ptr_q;
                        wrData_d = shift_q;
                        ptr_d    = ptr_q + PtrOne;
                        sda_d    = 1'b0;
                        bitCnt_d = '0;
                        state_d  = WDATA_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (sclFall) begin
                        sda_d   = 1'b1;
                        state_d = WDATA;
                    end
                end
                RDATA: begin
                    if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            sda_d    = 1'b1;
                            bitCnt_d = '0;
                            state_d  = RDATA_ACK;
                        end else begin
                            sda_d    = rdByte_q[3'd7 - bitCnt_q[2:0]];
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    // A fall is only seen here after an ACKed rise; a NACK leaves for IGNORE first.
                    if (sclRise) begin
                        if (!bus.i_sda) begin
                            rdEn_d   = 1'b1;
                            rdAddr_d = ptr_q;
                            ptr_d    = ptr_q + PtrOne;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                    if (sclFall) begin
                        sda_d    = rdByte_q[7];
                        bitCnt_d = 4'd1;
                        state_d  = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_sda     = sda_q;
    assign bus.o_wr_en   = wrEn_q;
    assign bus.o_wr_addr = wrAddr_q;
    assign bus.o_wr_data = wrData_q;
    assign bus.o_rd_en   = rdEn_q;
    assign bus.o_rd_addr = rdAddr_q;
    assign o_start_det   = startDet_q;
    assign o_stop_det    = stopDet_q;
    assign o_busy        = (state_q == ADDR_ACK) || (state_q == PTR) || (state_q == PTR_ACK) ||
                           (state_q == WDATA) || (state_q == WDATA_ACK) ||
                           (state_q == RDATA) || (state_q == RDATA_ACK);

endmodule

// File: tb/tb_i2c_passthru_tgt_regs.sv
// Bench for i2c_passthru_tgt_regs: a bit-banged I2C master plus an external register file,
// with register strobes checked by a scoreboard against a transaction-level model.
module tb_i2c_passthru_tgt_regs;

    typedef struct {
        int addr;
        int data;
    } wrExp_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       mScl = 1'b1;
    logic       mSda = 1'b1;
    logic [7:0] rdData;
    logic       pEn   = 1'b0;
    logic [3:0] pAddr = 4'h0;
    logic [7:0] pData = 8'h00;
    logic [7:0] regs [16];
    logic       busy, startDet, stopDet;

    int checks = 0;
    int errors = 0;
    int startsIssued = 0, stopsIssued = 0;
    int startPulses = 0, stopPulses = 0;
    int sdaLowCnt = 0, busyCnt = 0;

    // Transaction-level model: register contents and the target's register pointer.
    int         modelRegs [16];
    int         modelPtr = 0;
    wrExp_t     expWr [$];
    int         expRd [$];
    logic [7:0] txq [$];

    always #5 clk = ~clk;

    i2c_passthru_tgt_regs_if #(.REG_AW(4)) bus ();

    // Open-drain bus: wired-AND of the master's and the target's SDA.
    assign bus.i_scl     = mScl;
    assign bus.i_sda     = mSda & bus.o_sda;
    assign bus.i_rd_data = rdData;

    i2c_passthru_tgt_regs #(.TGT_ADDR(7'h50), .REG_AW(4)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .bus         (bus),
        .o_busy      (busy),
        .o_start_det (startDet),
        .o_stop_det  (stopDet)
    );

    // External register file: write strobes land here, read data returns the next cycle.
    always @(posedge clk) begin
        if (pEn) regs[pAddr] <= pData;
        else if (bus.o_wr_en) regs[bus.o_wr_addr] <= bus.o_wr_data;
        if (bus.o_rd_en) rdData <= regs[bus.o_rd_addr];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT raises a register strobe.
    task automatic monitorLoop();
        wrExp_t e;
        int     a;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bus.o_wr_en) begin
                    if (expWr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_wr addr=%0d data=0x%0h required=no strobe",
                                 bus.o_wr_addr, bus.o_wr_data);
                    end else begin
                        e = expWr.pop_front();
                        checkOutput("wr_addr", int'(bus.o_wr_addr), e.addr);
                        checkOutput("wr_data", int'(bus.o_wr_data), e.data);
                    end
                end
                if (bus.o_rd_en) begin
                    if (expRd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_rd addr=%0d required=no strobe", bus.o_rd_addr);
                    end else begin
                        a = expRd.pop_front();
                        checkOutput("rd_addr", int'(bus.o_rd_addr), a);
                    end
                end
                if (startDet)    startPulses++;
                if (stopDet)     stopPulses++;
                if (!bus.o_sda)  sdaLowCnt++;
                if (busy)        busyCnt++;
            end
        end
    endtask

    task automatic preload(input int a, input int d);
        pAddr = 4'(a);
        pData = 8'(d);
        pEn   = 1'b1;
        @(negedge clk);
        pEn = 1'b0;
        modelRegs[a] = d;
    endtask

    task automatic i2cStart();
        mSda = 1'b1;
        waitClk(2);
        mScl = 1'b1;
        waitClk(4);
        mSda = 1'b0;
        waitClk(4);
        mScl = 1'b0;
        waitClk(2);
        startsIssued++;
    endtask

    task automatic i2cStop();
        mSda = 1'b0;
        waitClk(2);
        mScl = 1'b1;
        waitClk(4);
        mSda = 1'b1;
        waitClk(4);
        stopsIssued++;
    endtask

    task automatic writeBit(input logic b);
        mSda = b;
        waitClk(4);
        mScl = 1'b1;
        waitClk(6);
        mScl = 1'b0;
        waitClk(2);
    endtask

    task automatic readBit(output logic b);
        mSda = 1'b1;
        waitClk(4);
        mScl = 1'b1;
        waitClk(3);
        b = bus.i_sda;
        waitClk(3);
        mScl = 1'b0;
        waitClk(2);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) writeBit(b[i]);
        readBit(v);
        ack = ~v;
    endtask

    task automatic readByte(output logic [7:0] b, input logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            readBit(v);
            b[i] = v;
        end
        writeBit(~ack);
    endtask

    // Write transaction: first byte in txq is the pointer, the rest are data bytes.
    task automatic doWrite(input logic [6:0] a7, input bit sendStop);
        logic   ack;
        bit     matched;
        wrExp_t e;
        matched = (a7 == 7'h50);
        i2cStart();
        writeByte({a7, 1'b0}, ack);
        checkOutput("addr_ack_w", int'(ack), int'(matched));
        if (matched) checkOutput("busy_addressed", int'(busy), 1);
        for (int i = 0; i < txq.size(); i++) begin
            if (matched) begin
                if (i == 0) begin
                    modelPtr = int'(txq[0]) % 16;
                end else begin
                    e.addr = modelPtr;
                    e.data = int'(txq[i]);
                    expWr.push_back(e);
                    modelRegs[modelPtr] = int'(txq[i]);
                    modelPtr = (modelPtr + 1) % 16;
                end
            end
            writeByte(txq[i], ack);
            checkOutput("data_ack", int'(ack), int'(matched));
        end
        if (sendStop) i2cStop();
    endtask

    // Read transaction of n bytes from the current pointer; master NACKs the last byte.
    task automatic doRead(input logic [6:0] a7, input int n, input bit sendStop);
        logic       ack;
        logic [7:0] b;
        bit         matched;
        int         cur, nxt;
        matched = (a7 == 7'h50);
        cur = modelPtr;
        nxt = cur;
        i2cStart();
        if (matched) begin
            expRd.push_back(cur);
            modelPtr = (modelPtr + 1) % 16;
        end
        writeByte({a7, 1'b1}, ack);
        checkOutput("addr_ack_r", int'(ack), int'(matched));
        if (matched) begin
            for (int i = 0; i < n; i++) begin
                if (i != n - 1) begin
                    nxt = modelPtr;
                    expRd.push_back(nxt);
                    modelPtr = (modelPtr + 1) % 16;
                end
                readByte(b, i != n - 1);
                checkOutput("rd_byte", int'(b), modelRegs[cur]);
                cur = nxt;
            end
            checkOutput("sda_released_after_nack", int'(bus.o_sda), 1);
        end
        if (sendStop) i2cStop();
    endtask

    // Randomised mix of matched/unmatched reads and writes of random length.
    task automatic applyStimulus(input int count);
        int         a;
        int         n;
        logic [6:0] a7;
        for (int t = 0; t < count; t++) begin
            a7 = 7'h50;
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom_range(0, 127));
                if (a == 'h50) a = 'h51;
                a7 = 7'(a);
            end
            n = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                txq.delete();
                for (int i = 0; i < n; i++) txq.push_back(8'($urandom_range(0, 255)));
                doWrite(a7, 1'b1);
            end else begin
                doRead(a7, n, 1'b1);
            end
            checkOutput("busy_idle_after_txn", int'(busy), 0);
        end
    endtask

    initial begin
        int lowSnap, busySnap, stopSnap;
        logic ack;

        fork
            monitorLoop();
        join_none

        // Reset values while held in reset.
        waitClk(3);
        checkOutput("reset_sda", int'(bus.o_sda), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_wr_en", int'(bus.o_wr_en), 0);
        checkOutput("reset_rd_en", int'(bus.o_rd_en), 0);
        checkOutput("reset_wr_addr", int'(bus.o_wr_addr), 0);
        checkOutput("reset_rd_addr", int'(bus.o_rd_addr), 0);
        rstn = 1'b1;
        waitClk(3);
        for (int i = 0; i < 16; i++) preload(i, int'($urandom_range(0, 255)));

        // Plain write transfer: pointer 3, two data bytes.
        stopSnap = stopPulses;
        txq.delete();
        txq.push_back(8'h03); txq.push_back(8'hA5); txq.push_back(8'h5A);
        doWrite(7'h50, 1'b1);
        checkOutput("stop_pulse", stopPulses - stopSnap, 1);
        checkOutput("busy_after_write", int'(busy), 0);

        // Pointer write, repeated START, two-byte read.
        preload(2, 'hC3);
        preload(3, 'h3C);
        txq.delete();
        txq.push_back(8'h02);
        doWrite(7'h50, 1'b0);
        doRead(7'h50, 2, 1'b1);
        checkOutput("busy_after_read", int'(busy), 0);

        // Foreign address: target stays silent and idle.
        lowSnap  = sdaLowCnt;
        busySnap = busyCnt;
        txq.delete();
        txq.push_back(8'h00); txq.push_back(8'hFF);
        doWrite(7'h51, 1'b1);
        checkOutput("mismatch_sda_low_cycles", sdaLowCnt - lowSnap, 0);
        checkOutput("mismatch_busy_cycles", busyCnt - busySnap, 0);

        // Pointer wrap from 15 to 0.
        txq.delete();
        txq.push_back(8'h0F); txq.push_back(8'h11); txq.push_back(8'h22);
        doWrite(7'h50, 1'b1);

        // Abort: STOP after four bits of a data byte.
        i2cStart();
        writeByte(8'hA0, ack);
        checkOutput("abort_addr_ack", int'(ack), 1);
        modelPtr = 6;
        writeByte(8'h06, ack);
        checkOutput("abort_ptr_ack", int'(ack), 1);
        for (int i = 0; i < 4; i++) writeBit(1'($urandom_range(0, 1)));
        i2cStop();
        waitClk(2);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_sda", int'(bus.o_sda), 1);
        txq.delete();
        txq.push_back(8'h07); txq.push_back(8'h99);
        doWrite(7'h50, 1'b1);

        // Asynchronous reset while the target is driving a 0 data bit.
        preload(5, 'h12);
        txq.delete();
        txq.push_back(8'h05);
        doWrite(7'h50, 1'b0);
        i2cStart();
        expRd.push_back(5);
        modelPtr = 6;
        writeByte(8'hA1, ack);
        checkOutput("rst_read_addr_ack", int'(ack), 1);
        waitClk(1);
        checkOutput("rst_sda_driving_bit7", int'(bus.o_sda), 0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_rst_sda", int'(bus.o_sda), 1);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_rd_addr", int'(bus.o_rd_addr), 0);
        checkOutput("async_rst_wr_addr", int'(bus.o_wr_addr), 0);
        checkOutput("async_rst_wr_data", int'(bus.o_wr_data), 0);
        checkOutput("async_rst_strobes", int'({bus.o_wr_en, bus.o_rd_en, startDet, stopDet}), 0);
        mScl = 1'b1;
        mSda = 1'b1;
        waitClk(3);
        rstn = 1'b1;
        modelPtr = 0;
        waitClk(3);
        txq.delete();
        txq.push_back(8'h03); txq.push_back(8'hA5); txq.push_back(8'h5A);
        doWrite(7'h50, 1'b1);
        checkOutput("busy_after_reset_write", int'(busy), 0);

        applyStimulus(25);

        waitClk(4);
        checkOutput("wr_queue_drained", expWr.size(), 0);
        checkOutput("rd_queue_drained", expRd.size(), 0);
        checkOutput("start_pulse_count", startPulses, startsIssued);
        checkOutput("stop_pulse_count", stopPulses, stopsIssued);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
